xor_flip_decoder: RTL
=====================

# xor_flip_decoder

Receive-side decoder for the two-bit-flip word stream produced by the xor_flip register. It compares each accepted word against the previous one and recovers the two flipped bit positions as an ordered index pair. It flags any transition that is not exactly two flips, and resynchronises after repeated errors. It sits between the monitored register tap and downstream consumers, behind a one-stage valid/ready output register.

## Interface
- W, 32, word width; power of two, ≥4
- IDX_W, $clog2(W), index width
- CNT_W, 16, error-counter width
- LOSS_LIMIT, 3, consecutive errors that force LOST state; ≥1
- clk  in  1  clock; all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  in_word valid
- in_ready  out  1  decoder can accept in_word this cycle
- in_word  in  W  observed register value
- out_valid  out  1  decoded result held in output register
- out_ready  in  1  consumer takes result this cycle
- out_i  out  IDX_W  lower flipped index
- out_j  out  IDX_W  higher flipped index
- out_err  out  1  transition was not exactly two flips
- lost  out  1  decoder in LOST state (awaiting resync word)
- err_cnt  out  CNT_W  saturating count of out_err results emitted

## Operation
- Accept = in_valid && in_ready. in_ready = !out_valid || out_ready. Combinational from out_valid/out_ready only, never from in_valid.
- Reference register prev (W bits) resets to 0, matching the encoder reset value.
- State TRACK (reset state), on accept:
  - diff = in_word ^ prev; prev <= in_word unconditionally.
  - popcount(diff)==2: out_i = index of lowest set bit, out_j = index of highest set bit (out_i < out_j always), out_err=0, consecutive-error count cleared.
  - otherwise (0, 1, or ≥3 bits): out_i=out_j=0, out_err=1, err_cnt += 1 unless all-ones, consecutive-error count += 1.
  - Result loaded into output register, out_valid=1.
  - If consecutive count reaches LOSS_LIMIT on this accept → LOST. The erroring result is still emitted.
- State LOST (lost=1), on accept: prev <= in_word, no result produced (out_valid unaffected), consecutive count cleared → TRACK.
- Output register: cleared out_valid when out_ready && !accept-with-result. Loaded when accept-with-result, including the same-cycle drain case.
- Consecutive-error count width: $clog2(LOSS_LIMIT+1); saturates at LOSS_LIMIT.

## Timing
- Reset values: out_valid=0, out_i=0, out_j=0, out_err=0, lost=0, err_cnt=0, prev=0, state TRACK. These values take effect immediately on rst_n low, independent of clk.
- Latency: word accepted at edge N → result visible after edge N (1 cycle).
- Throughput: one word per cycle while out_ready=1.
- Backpressure: out_valid && !out_ready holds out_i/out_j/out_err stable and forces in_ready=0. No word is dropped or duplicated.
- LOST entry: lost rises after the edge that accepts the LOSS_LIMIT-th consecutive error. It falls after the edge that accepts the resync word.
- Reset mid-stream: a pending output is discarded, prev returns to 0, and the next accepted word is decoded against 0.
- err_cnt updates on the same edge the erroring result is loaded, not when it is consumed.

## Test plan
- Reset, out_ready=1, feed 0x0000_0003 → after 1 cycle out_valid=1, out_i=0, out_j=1, out_err=0.
- Continue with 0x8000_0002: diff is 0x8000_0001 → out_i=0, out_j=31, out_err=0. Then feed 0x8000_0002 again (diff 0) → out_err=1, out_i=out_j=0, err_cnt=1.
- Feed three consecutive single-flip words (0x1, 0x0, 0x1 from prev 0x0): three results with out_err=1, then lost=1. Next word 0xF0F0_0000 produces no output, lost=0. Then 0xF0F0_0005 → out_i=0, out_j=2.
- out_ready low for 3 cycles with in_valid high and two words pending: in_ready=0 and out_* stable throughout. After out_ready rises, both words decode in order, one per cycle.
- Force err_cnt to all-ones via CNT_W=2 build with 5 error words → err_cnt stays 3.
- Assert rst_n low asynchronously between edges while out_valid=1 → out_valid=0 before the next edge. After release, 0x0000_0011 decodes to out_i=0, out_j=4.

Source files
------------

// File: rtl/xor_flip_decoder.sv
// ============================================================================
// Module   : xor_flip_decoder
// Purpose  : Receive-side decoder for a two-bit-flip word stream. It recovers
//            the flipped index pair from each word-to-word transition, flags
//            transitions that are not exactly two flips, and resynchronises
//            after repeated errors. Results leave through a one-stage
//            valid/ready output register.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module xor_flip_decoder #(
    parameter int W          = 32,
    parameter int IDX_W      = $clog2(W),
    parameter int CNT_W      = 16,
    parameter int LOSS_LIMIT = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_word,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDX_W-1:0] out_i,
    output logic [IDX_W-1:0] out_j,
    output logic             out_err,
    output logic             lost,
    output logic [CNT_W-1:0] err_cnt
);

    localparam int CONS_W = $clog2(LOSS_LIMIT + 1);
    localparam logic [CONS_W-1:0] C_LOSS_LIMIT = CONS_W'(LOSS_LIMIT);
    localparam logic [IDX_W:0]    C_TWO        = (IDX_W + 1)'(2);

    typedef enum logic [0:0] {
        TRACK = 1'b0,
        LOST  = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [W-1:0]      prev_q, prev_d;
    logic              out_valid_q, out_valid_d;
    logic [IDX_W-1:0]  out_i_q, out_i_d;
    logic [IDX_W-1:0]  out_j_q, out_j_d;
    logic              out_err_q, out_err_d;
    logic [CNT_W-1:0]  err_cnt_q, err_cnt_d;
    logic [CONS_W-1:0] cons_q, cons_d;

    logic [W-1:0]      w_diff;
    logic [IDX_W:0]    w_pop;
    logic [IDX_W-1:0]  w_lo;
    logic [IDX_W-1:0]  w_hi;
    logic              w_lo_found;
    logic              w_accept;

    // Ready depends only on the output register, never on in_valid.
    assign in_ready = !out_valid_q || out_ready;
    assign w_accept = in_valid && in_ready;
    assign w_diff   = in_word ^ prev_q;

    // Population count plus lowest/highest set-bit positions of the transition.
    always_comb begin
        w_pop      = '0;
        w_lo       = '0;
        w_hi       = '0;
        w_lo_found = 1'b0;
        for (int k = 0; k < W; k++) begin
            w_pop = w_pop + {{IDX_W{1'b0}}, w_diff[k]};
            if (w_diff[k]) begin
                w_hi = IDX_W'(k);
                if (!w_lo_found) begin
                    w_lo       = IDX_W'(k);
                    w_lo_found = 1'b1;
                end
            end
        end
    end

    // Next-state: tracking FSM, reference word, error counters, output register.
    always_comb begin
        state_d     = state_q;
        prev_d      = prev_q;
        out_valid_d = out_valid_q;
        out_i_d     = out_i_q;
        out_j_d     = out_j_q;
        out_err_d   = out_err_q;
        err_cnt_d   = err_cnt_q;
        cons_d      = cons_q;

        // Consumer drains the register; a same-cycle load below overrides this.
        if (out_ready) begin
            out_valid_d = 1'b0;
        end

        if (w_accept) begin
            prev_d = in_word;
            case (state_q)
                TRACK: begin
                    out_valid_d = 1'b1;
                    if (w_pop == C_TWO) begin
                        out_i_d   = w_lo;
                        out_j_d   = w_hi;
                        out_err_d = 1'b0;
                        cons_d    = '0;
                    end else begin
                        out_i_d   = '0;
                        out_j_d   = '0;
                        out_err_d = 1'b1;
                        if (err_cnt_q != {CNT_W{1'b1}}) begin
                            err_cnt_d = err_cnt_q + 1'b1;
                        end
                        if (cons_q < C_LOSS_LIMIT) begin
                            cons_d = cons_q + 1'b1;
                        end
                        // The erroring result is still emitted on LOST entry.
                        if (cons_q + 1'b1 >= C_LOSS_LIMIT) begin
                            state_d = LOST;
                        end
                    end
                end
                LOST: begin
                    // Resync word only re-seeds the reference; no result.
                    cons_d  = '0;
                    state_d = TRACK;
                end
                default: begin
                    state_d = TRACK;
                end
            endcase
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= TRACK;
            prev_q      <= '0;
            out_valid_q <= 1'b0;
            out_i_q     <= '0;
            out_j_q     <= '0;
            out_err_q   <= 1'b0;
            err_cnt_q   <= '0;
            cons_q      <= '0;
        end else begin
            state_q     <= state_d;
            prev_q      <= prev_d;
            out_valid_q <= out_valid_d;
            out_i_q     <= out_i_d;
            out_j_q     <= out_j_d;
            out_err_q   <= out_err_d;
            err_cnt_q   <= err_cnt_d;
            cons_q      <= cons_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_i     = out_i_q;
    assign out_j     = out_j_q;
    assign out_err   = out_err_q;
    assign lost      = (state_q == LOST);
    assign err_cnt   = err_cnt_q;

endmodule

`default_nettype wire
